// File: rtl/dibit_aggregate.sv
// rtl/dibit_aggregate.sv - packs a serial 2-bit symbol stream into one 32-bit word per frame
//
// Purpose:
//   Collects the first OUT_W/IN_W dibits of each frame, MSB first, and presents
//   them as one word with a single-cycle valid pulse. A frame is a contiguous run
//   of cycles with axiiv high. Symbols after the word completes are dropped until
//   axiiv falls. Frames that end early are discarded silently.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   axiiv  in   dibit valid, held high for the whole frame
//   axiid  in   IN_W-bit symbol, first received is most significant
//   axiov  out  one-cycle pulse, axiod holds a newly completed word
//   axiod  out  OUT_W-bit aggregated word, held until the next completion

module dibit_aggregate #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [IN_W-1:0]  axiid,
    output logic             axiov,
    output logic [OUT_W-1:0] axiod
);

    localparam int NSYM = OUT_W / IN_W;
    localparam int CW   = $clog2(NSYM);
    localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [OUT_W-1:0] sr_q,    sr_d;
    logic             done_q,  done_d;
    logic             axiov_q, axiov_d;
    logic [OUT_W-1:0] axiod_q, axiod_d;
    logic [OUT_W-1:0] shifted;

    assign shifted = {sr_q[OUT_W-IN_W-1:0], axiid};

    always_comb begin
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done_d  = done_q;
        axiov_d = 1'b0;
        axiod_d = axiod_q;
        if (!axiiv) begin
            // Any idle cycle closes the frame; the last completed word stays visible.
            cnt_d  = '0;
            sr_d   = '0;
            done_d = 1'b0;
        end else if (!done_q) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                // Counter wraps to zero here; done_q blocks further counting this frame.
                axiod_d = shifted;
                axiov_d = 1'b1;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule

// File: tb/tb_dibit_aggregate.sv
// tb/tb_dibit_aggregate.sv - directed self-checking bench for dibit_aggregate

module tb_dibit_aggregate;

    logic        clk;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [31:0] axiod;

    int n_checks;
    int n_errors;

    dibit_aggregate #(.IN_W(2), .OUT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample axiov at the falling edge, then change inputs for the next rising edge.
    task automatic drive(input logic v, input logic [1:0] d, output logic p);
        @(negedge clk);
        p     = axiov;
        axiiv = v;
        axiid = d;
    endtask

    // Sends n dibits MSB-first from data, then one idle cycle. Reports the number
    // of pulses seen and the dibit slot at which the last one was observed
    // (slot n means it showed up during the trailing idle cycle).
    task automatic send_frame(input logic [63:0] data, input int n,
                              output int npulse, output int idx);
        logic p;
        npulse = 0;
        idx    = -1;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, data[63-2*i -: 2], p);
            if (p) begin npulse++; idx = i; end
        end
        drive(1'b0, 2'b00, p);
        if (p) begin npulse++; idx = n; end
    endtask

    task automatic idle(input int k, output int npulse);
        logic p;
        npulse = 0;
        for (int i = 0; i < k; i++) begin
            drive(1'b0, 2'b00, p);
            if (p) npulse++;
        end
    endtask

    initial begin
        int np, ix, ni;
        logic p;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_axiov", {31'd0, axiov}, 32'd0);
        check("reset_axiod", axiod, 32'h0);
        rst = 1'b0;
        idle(3, ni);
        check("idle_axiov", {31'd0, axiov}, 32'd0);
        check("idle_axiod", axiod, 32'h0);

        // Two-dibit runt frame, then 500 ns idle
        send_frame(64'h0, 2, np, ix);
        idle(25, ni);
        check("short2_pulses", 32'(np + ni), 32'd0);
        check("short2_axiod", axiod, 32'h0);

        // Exactly 16 dibits of zero: pulse lands in the cycle after the 16th dibit
        send_frame(64'h0, 16, np, ix);
        idle(4, ni);
        check("f16_pulses", 32'(np + ni), 32'd1);
        check("f16_pulse_slot", 32'(ix), 32'd16);
        check("f16_axiod", axiod, 32'h0);

        // 32-dibit frame: only the first word is emitted
        send_frame(64'h12345678_00000000, 32, np, ix);
        check("f32_pulses", 32'(np), 32'd1);
        check("f32_pulse_slot", 32'(ix), 32'd16);
        check("f32_axiod", axiod, 32'h12345678);
        idle(10, ni);
        check("f32_idle_pulses", 32'(ni), 32'd0);
        check("f32_hold", axiod, 32'h12345678);

        // Same frame again after the gap: counter must restart from zero
        send_frame(64'h12345678_00000000, 32, np, ix);
        idle(3, ni);
        check("f32b_pulses", 32'(np + ni), 32'd1);
        check("f32b_pulse_slot", 32'(ix), 32'd16);
        check("f32b_axiod", axiod, 32'h12345678);

        // 15 dibits, one short of a word: no pulse, axiod untouched
        send_frame(64'hFFFFFFFF_FFFFFFFF, 15, np, ix);
        idle(3, ni);
        check("f15_pulses", 32'(np + ni), 32'd0);
        check("f15_axiod", axiod, 32'h12345678);

        // Reset in the middle of a frame, axiiv kept high through it
        for (int i = 0; i < 8; i++) drive(1'b1, 2'b11, p);
        @(posedge clk);
        #3 rst = 1'b1;
        #2;
        check("midrst_axiov", {31'd0, axiov}, 32'd0);
        check("midrst_axiod", axiod, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_frame({32'hDEADBEEF, 32'h0}, 16, np, ix);
        idle(3, ni);
        check("postrst_pulses", 32'(np + ni), 32'd1);
        check("postrst_pulse_slot", 32'(ix), 32'd16);
        check("postrst_axiod", axiod, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
